sine_wave_sequencer: RTL and testbench
======================================

SINE_WAVE_SEQUENCER -- requirements
Module: sine_wave_sequencer

Interface
REQ-001 Parameter DIV, default 32, meaning clock cycles per output sample; legal range 24..65535.
REQ-002 Parameter PHASE_W, default 16, meaning phase accumulator width; fixed at 16 in this revision.
REQ-003 Port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1, synchronous active-high reset.
REQ-005 Port enable, input, 1, runs the sample-tick counter while high.
REQ-006 Port step, input, 16, phase increment per sample (frequency = step * f_clk / (DIV * 2^16)).
REQ-007 Port cordic_angle, output, 16, first-quadrant angle in radians to the CORDIC stage, unsigned 2.14.
REQ-008 Port cordic_start, output, 1, CORDIC initialise strobe, exactly one cycle high per conversion.
REQ-009 Port cordic_sint, input, 8, CORDIC result, unsigned 2.6, gain-unscaled.
REQ-010 Port cordic_done, input, 1, CORDIC result-valid level.
REQ-011 Port sample, output, 8, signed two's-complement 2.6 sine sample.
REQ-012 Port sample_valid, output, 1, one-cycle pulse when sample updates.
REQ-013 Port busy, output, 1, high in every state except IDLE.
REQ-014 Port overrun, output, 1, sticky flag: tick arrived while busy.

Function
REQ-015 Tick counter counts 0..DIV-1 while enable=1, wraps to 0, and raises an internal tick on reaching DIV-1; it holds its value while enable=0.
REQ-016 FSM states: IDLE, LAUNCH, WAIT, EMIT; IDLE->LAUNCH on tick; LAUNCH->WAIT unconditionally; WAIT->EMIT when cordic_done=1; EMIT->IDLE unconditionally.
REQ-017 On the IDLE->LAUNCH transition, phase is captured into a conversion register and the accumulator advances by step, modulo 2^16.
REQ-018 Quadrant q = captured phase[15:14], fraction f = phase[13:0]; f' = f for q in {0,2}, f' = 16384 - f for q in {1,3} (15-bit unsigned).
REQ-019 cordic_angle = (f' * 16'h6488) >> 14, truncated, registered, and held stable from LAUNCH through WAIT; maximum 16'h6488.
REQ-020 Negate flag = q[1]; it is registered with the angle.
REQ-021 cordic_start = 1 only during LAUNCH; the CORDIC stage clears done on that edge, so WAIT samples cordic_done from the following cycle.
REQ-022 In EMIT: sample = negate ? -cordic_sint : cordic_sint (8-bit two's complement), and sample_valid = 1 for that cycle only.
REQ-023 sample holds its value between EMIT cycles.
REQ-024 Conversion latency: tick -> sample_valid = 3 + CORDIC latency cycles (20 with the 16-iteration CORDIC).
REQ-025 A tick while state != IDLE sets overrun, is dropped, and leaves phase unchanged; overrun clears only on rst.
REQ-026 When enable falls mid-conversion, the conversion completes and emits; no further ticks occur.
REQ-027 A change to step takes effect at the next accepted tick.

Reset
REQ-028 On rst: state=IDLE, tick counter=0, phase=0, cordic_angle=0, cordic_start=0, sample=0, sample_valid=0, overrun=0, busy=0.
REQ-029 rst mid-conversion abandons it, and no sample_valid follows; any late cordic_done is ignored in IDLE.

Structure
REQ-030 A shared package holds the state enumeration, PI_OVER_2 = 16'h6488, and the DIV default.
REQ-031 Phase-to-angle mapping (REQ-018..020) is implemented as the combinational sub-module quadrant_mapper.

Verification
REQ-032 rst, enable=1, step=16'h1000, with the CORDIC model: the first sample is from phase 0 (angle 0), giving sample=0; samples are spaced exactly DIV cycles apart.
REQ-033 Phase 16'h4000 -> angle 16'h6488, negate=0; model sint 8'h69 -> sample 8'h69.
REQ-034 Phase 16'hC000 -> angle 16'h6488, negate=1; sint 8'h69 -> sample 8'h97.
REQ-035 Phase 16'h2000 -> angle 16'h3244; phase 16'h6000 -> angle 16'h3244 (mirror).
REQ-036 Model done delayed 40 cycles with DIV=32 -> overrun=1, phase advances once per accepted tick only, and one sample_valid per conversion.
REQ-037 rst asserted during WAIT -> all outputs 0 the next cycle, no sample_valid; with enable held, the first sample after reset comes from phase 0.

Source files
------------

// File: rtl/sine_wave_sequencer_pkg.sv
// Shared types and constants for the sine wave sequencer.
package sine_wave_sequencer_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LAUNCH,
      ST_WAIT,
      ST_EMIT
   } state_t;

   // pi/2 in unsigned 2.14 radians
   localparam logic [15:0] PI_OVER_2 = 16'h6488;

   localparam int DIV_DEFAULT = 32;

endpackage

// File: rtl/sine_wave_sequencer_quadrant_mapper.sv
// Folds a 16-bit phase into a first-quadrant CORDIC angle
// plus a sign flag for the lower half of the circle.
module quadrant_mapper
   import sine_wave_sequencer_pkg::*;
(
   input  logic [15:0] phase,
   output logic [15:0] angle,
   output logic        negate
);

   logic [1:0]  quad;
   logic [13:0] frac;
   logic [14:0] folded;
   logic [29:0] prod;

   assign quad = phase[15:14];
   assign frac = phase[13:0];

   // quadrants 1 and 3 run the fraction backwards (mirror about pi/2)
   assign folded = quad[0] ? (15'd16384 - {1'b0, frac})
                           : {1'b0, frac};

   assign prod   = 30'(folded) * 30'(PI_OVER_2);
   assign angle  = prod[29:14];
   assign negate = quad[1];

endmodule

// File: rtl/sine_wave_sequencer.sv
// Sample-rate sequencer: advances a phase accumulator every DIV cycles,
// drives an external CORDIC and emits signed sine samples.
module sine_wave_sequencer
   import sine_wave_sequencer_pkg::*;
#(
   parameter int DIV     = DIV_DEFAULT,
   parameter int PHASE_W = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              enable,
   input  logic [PHASE_W-1:0] step,
   output logic [15:0]       cordic_angle,
   output logic              cordic_start,
   input  logic [7:0]        cordic_sint,
   input  logic              cordic_done,
   output logic [7:0]        sample,
   output logic              sample_valid,
   output logic              busy,
   output logic              overrun
);

   localparam int CNT_W = $clog2(DIV);

   state_t             state;
   logic [CNT_W-1:0]   cnt;
   logic               tick;
   logic [PHASE_W-1:0] phase;
   logic               negate;
   logic [15:0]        map_angle;
   logic               map_negate;

   assign tick = enable && (cnt == CNT_W'(DIV - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
      end else if (enable) begin
         cnt <= tick ? '0 : cnt + 1'b1;
      end
   end

   quadrant_mapper u_mapper (
      .phase  (phase),
      .angle  (map_angle),
      .negate (map_negate)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= ST_IDLE;
         phase        <= '0;
         cordic_angle <= '0;
         negate       <= 1'b0;
         cordic_start <= 1'b0;
         sample       <= '0;
         sample_valid <= 1'b0;
         busy         <= 1'b0;
         overrun      <= 1'b0;
      end else begin
         cordic_start <= 1'b0;
         sample_valid <= 1'b0;
         // a tick that finds a conversion in flight is lost
         if (tick && state != ST_IDLE) begin
            overrun <= 1'b1;
         end
         unique case (state)
            ST_IDLE: begin
               if (tick) begin
                  state        <= ST_LAUNCH;
                  phase        <= phase + step;
                  cordic_angle <= map_angle;
                  negate       <= map_negate;
                  cordic_start <= 1'b1;
                  busy         <= 1'b1;
               end
            end
            ST_LAUNCH: begin
               state <= ST_WAIT;
            end
            ST_WAIT: begin
               if (cordic_done) begin
                  state        <= ST_EMIT;
                  sample       <= negate ? -cordic_sint : cordic_sint;
                  sample_valid <= 1'b1;
               end
            end
            ST_EMIT: begin
               state <= ST_IDLE;
               busy  <= 1'b0;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sine_wave_sequencer.sv
// Scoreboard bench for sine_wave_sequencer with a behavioural CORDIC
// and a phase/tick reference model.
module tb_sine_wave_sequencer;

   localparam int DIV = 32;

   logic        clk = 1'b0;
   logic        rst;
   logic        enable;
   logic [15:0] step;
   logic [15:0] cordic_angle;
   logic        cordic_start;
   logic [7:0]  cordic_sint = 8'd0;
   logic        cordic_done = 1'b0;
   logic [7:0]  sample;
   logic        sample_valid;
   logic        busy;
   logic        overrun;

   always #5 clk = ~clk;

   sine_wave_sequencer #(.DIV(DIV), .PHASE_W(16)) dut (
      .clk          (clk),
      .rst          (rst),
      .enable       (enable),
      .step         (step),
      .cordic_angle (cordic_angle),
      .cordic_start (cordic_start),
      .cordic_sint  (cordic_sint),
      .cordic_done  (cordic_done),
      .sample       (sample),
      .sample_valid (sample_valid),
      .busy         (busy),
      .overrun      (overrun)
   );

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int lat = 17;

   always @(posedge clk) cyc <= cyc + 1;

   // gain-unscaled sine in 2.6, truncated toward zero
   function automatic logic [7:0] sint_of(logic [15:0] a);
      real r;
      r = $sin(real'(a) / 16384.0) * 1.646760258 * 64.0;
      return 8'($rtoi(r));
   endfunction

   function automatic logic [15:0] angle_of(logic [15:0] p);
      int q, f, fp;
      q  = int'(p) / 16384;
      f  = int'(p) % 16384;
      fp = (q % 2 == 1) ? 16384 - f : f;
      return 16'((fp * 25736) / 16384);
   endfunction

   int          ccnt = 0;
   logic [15:0] cang = 16'd0;

   always @(posedge clk) begin
      if (cordic_start) begin
         ccnt        <= lat;
         cordic_done <= 1'b0;
         cang        <= cordic_angle;
      end else if (ccnt > 0) begin
         ccnt <= ccnt - 1;
         if (ccnt == 1) begin
            cordic_done <= 1'b1;
            cordic_sint <= sint_of(cang);
         end
      end
   end

   typedef struct {
      logic [7:0] smp;
      int         tcyc;
   } exp_t;

   exp_t        sq[$];
   logic [15:0] aq[$];

   int          mcnt = 0;
   logic [15:0] mphase = 16'd0;
   int          free_at = 0;
   int          exp_ovr = 0;

   task automatic check(string name, int act, int req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at cycle %0d",
                  name, act, req, cyc);
      end
   endtask

   task automatic model_cycle();
      bit          tk;
      logic [15:0] a;
      logic [7:0]  s;
      tk = !rst && enable && (mcnt == DIV - 1);
      if (rst) begin
         mcnt    = 0;
         mphase  = 16'd0;
         free_at = 0;
         exp_ovr = 0;
         sq.delete();
         aq.delete();
      end else begin
         if (enable) mcnt = tk ? 0 : mcnt + 1;
         if (tk) begin
            if (cyc >= free_at) begin
               a = angle_of(mphase);
               s = sint_of(a);
               if (mphase >= 16'h8000) s = -s;
               aq.push_back(a);
               sq.push_back('{s, cyc});
               mphase  = mphase + step;
               free_at = cyc + lat + 4;
            end else begin
               exp_ovr = 1;
            end
         end
      end
   endtask

   task automatic run(int n);
      repeat (n) begin
         model_cycle();
         @(negedge clk);
      end
   endtask

   initial begin
      forever begin
         @(negedge clk);
         if (cordic_start === 1'b1) begin
            if (aq.size() == 0) begin
               check("unexpected_start", 1, 0);
            end else begin
               check("angle", cordic_angle, aq.pop_front());
            end
         end
         if (sample_valid === 1'b1) begin
            if (sq.size() == 0) begin
               check("unexpected_valid", 1, 0);
            end else begin
               exp_t e;
               e = sq.pop_front();
               check("sample", sample, e.smp);
               check("latency", cyc - e.tcyc, lat + 3);
            end
         end
      end
   end

   initial begin
      rst    = 1'b1;
      enable = 1'b0;
      step   = 16'd0;
      @(negedge clk);
      run(2);
      check("reset_state",
            {cordic_angle, cordic_start, sample, sample_valid, busy, overrun},
            0);

      rst    = 1'b0;
      enable = 1'b1;
      step   = 16'h1000;
      run(DIV * 18);
      check("no_overrun_fixed", overrun, exp_ovr);

      repeat (40) begin
         step   = 16'($urandom);
         enable = ($urandom_range(0, 3) != 0);
         run($urandom_range(1, 40));
      end
      check("no_overrun_random", overrun, exp_ovr);

      enable = 1'b0;
      run(60);
      lat    = 40;
      step   = 16'h0700;
      enable = 1'b1;
      run(DIV * 8);
      check("overrun_set", overrun, exp_ovr);
      enable = 1'b0;
      run(60);
      check("overrun_sticky", overrun, exp_ovr);
      lat = 17;

      step   = 16'h3000;
      enable = 1'b1;
      for (int i = 0; i < 4 * DIV && sq.size() == 0; i++) run(1);
      check("tick_seen", int'(sq.size()), 1);
      run(5);
      rst = 1'b1;
      run(1);
      rst = 1'b0;
      check("reset_in_wait",
            {cordic_angle, cordic_start, sample, sample_valid, busy, overrun},
            0);
      run(DIV * 4);

      enable = 1'b0;
      run(60);
      check("drained", int'(sq.size()), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
